// File: rtl/adder_flit_injector_pkg.sv
// Shared types and the transition-pattern ROM for the adder characterization
// stimulus path.
package adder_char_pkg;

  localparam int ROM_DEPTH = 24;
  localparam int ROM_W     = 60;

  // Thermometer-style words: long runs of ones/zeros with one boundary, so
  // consecutive flits toggle large contiguous bit ranges.
  localparam logic [ROM_W-1:0] PATTERN_ROM [ROM_DEPTH] = '{
    60'h000000000000000, 60'hFFFFFFFFE000000, 60'h003FFFFFFFFFFFF, 60'h000000000007FFF,
    60'hFFFFF0000000000, 60'h0000000FFFFFFFF, 60'hFFFFFFFFFFFF000, 60'h00000000000000F,
    60'hFFFF00000000000, 60'h0000FFFFFFFFFFF, 60'hFFFFFFFFFFFFFF0, 60'h000000003FFFFFF,
    60'hFFFFFFFFFFFFFFF, 60'h00000FFFFFFFFFF, 60'hFFFFFFC00000000, 60'h0000000000003FF,
    60'hFFFFFFFFFF80000, 60'h001FFFFFFFFFFFF, 60'hF00000000000000, 60'h0000000001FFFFF,
    60'hFFFFFFFF0000000, 60'h00000000000FFFF, 60'hFFF800000000000, 60'h07FFFFFFFFFFFFF
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_e;

  function automatic logic [4:0] next_idx(input logic [4:0] idx);
    return (idx == 5'(ROM_DEPTH - 1)) ? '0 : idx + 5'd1;
  endfunction

endpackage

// File: rtl/adder_flit_injector_if.sv
// Operand flit handshake between the injector and the adder under test.
interface adder_flit_injector_if #(
  parameter int N = 30
);
  logic         op_valid;
  logic         op_ready;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         last_flit;

  modport master (output op_valid, op_a, op_b, last_flit, input op_ready);
  modport slave  (input op_valid, op_a, op_b, last_flit, output op_ready);
endinterface

// File: rtl/adder_flit_injector_pattern_rom.sv
// Combinational index-to-word lookup into the shared pattern ROM.
module pattern_rom
  import adder_char_pkg::*;
#(
  parameter int N = 30
) (
  input  logic [4:0]     idx,
  output logic [2*N-1:0] word
);

  logic [ROM_W-1:0] entry;

  always_comb begin
    entry = '0;
    if (int'(idx) < ROM_DEPTH) entry = PATTERN_ROM[idx];
    word = entry[2*N-1:0];
  end

endmodule

// File: rtl/adder_flit_injector.sv
// Packetized operand-stream generator feeding the adder under energy
// characterization; all outputs registered.
module adder_flit_injector
  import adder_char_pkg::*;
#(
  parameter int N       = 30,
  parameter int PAYLOAD = 20,
  parameter int GAP     = 7,
  parameter int NUM_PKT = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  adder_flit_injector_if.master op,
  output logic [7:0]            pkt_cnt,
  output logic                  busy,
  output logic                  window,
  output logic                  done
);

  localparam logic [7:0] LAST_FLIT  = 8'(PAYLOAD - 1);
  localparam logic [7:0] LAST_PKT   = 8'(NUM_PKT - 1);
  localparam logic [7:0] GAP_LEN    = 8'(GAP);
  localparam logic       FIRST_LAST = (PAYLOAD == 1);

  state_e         state_q, state_d;
  logic [7:0]     flit_cnt_q, flit_cnt_d;
  logic [7:0]     gap_cnt_q, gap_cnt_d;
  logic [7:0]     pkt_cnt_q, pkt_cnt_d;
  logic [4:0]     idx_q, idx_d;
  logic           op_valid_q, op_valid_d;
  logic [N-1:0]   op_a_q, op_a_d;
  logic [N-1:0]   op_b_q, op_b_d;
  logic           last_q, last_d;
  logic           busy_q, busy_d;
  logic           window_q, window_d;
  logic           done_q, done_d;
  logic           load;
  logic [2*N-1:0] rom_word;

  pattern_rom #(.N(N)) u_rom (
    .idx  (idx_d),
    .word (rom_word)
  );

  // done is registered from the DONE state, so it appears while the FSM is
  // already back in IDLE; a start seen together with it must be dropped.
  always_comb begin
    state_d    = state_q;
    flit_cnt_d = flit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    idx_d      = idx_q;
    op_valid_d = op_valid_q;
    last_d     = last_q;
    busy_d     = busy_q;
    window_d   = window_q;
    done_d     = 1'b0;
    load       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !done_q) begin
          pkt_cnt_d = '0;
          if (NUM_PKT > 0) begin
            state_d    = ST_SEND;
            flit_cnt_d = '0;
            idx_d      = 5'd1;
            load       = 1'b1;
            op_valid_d = 1'b1;
            last_d     = FIRST_LAST;
            busy_d     = 1'b1;
            window_d   = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SEND: begin
        if (op_valid_q && op.op_ready) begin
          if (!last_q) begin
            flit_cnt_d = flit_cnt_q + 8'd1;
            idx_d      = next_idx(idx_q);
            load       = 1'b1;
            last_d     = (flit_cnt_q + 8'd1 == LAST_FLIT);
          end else if (pkt_cnt_q == LAST_PKT) begin
            state_d    = ST_DONE;
            op_valid_d = 1'b0;
            last_d     = 1'b0;
            busy_d     = 1'b0;
            window_d   = 1'b0;
          end else if (GAP_LEN != 8'd0) begin
            state_d    = ST_GAP;
            op_valid_d = 1'b0;
            last_d     = 1'b0;
            gap_cnt_d  = GAP_LEN;
          end else begin
            pkt_cnt_d  = pkt_cnt_q + 8'd1;
            flit_cnt_d = '0;
            idx_d      = 5'd1;
            load       = 1'b1;
            last_d     = FIRST_LAST;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 8'd1) begin
          state_d    = ST_SEND;
          pkt_cnt_d  = pkt_cnt_q + 8'd1;
          flit_cnt_d = '0;
          idx_d      = 5'd1;
          load       = 1'b1;
          op_valid_d = 1'b1;
          last_d     = FIRST_LAST;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operands change only when a new flit is loaded; otherwise they hold.
  always_comb begin
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    if (load) begin
      op_a_d = rom_word[N-1:0];
      op_b_d = rom_word[2*N-1:N];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      flit_cnt_q <= '0;
      gap_cnt_q  <= '0;
      pkt_cnt_q  <= '0;
      idx_q      <= '0;
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      window_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      flit_cnt_q <= flit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      idx_q      <= idx_d;
      op_valid_q <= op_valid_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      window_q   <= window_d;
      done_q     <= done_d;
    end
  end

  assign op.op_valid  = op_valid_q;
  assign op.op_a      = op_a_q;
  assign op.op_b      = op_b_q;
  assign op.last_flit = last_q;
  assign pkt_cnt      = pkt_cnt_q;
  assign busy         = busy_q;
  assign window       = window_q;
  assign done         = done_q;

endmodule

// File: tb/tb_adder_flit_injector.sv
// Scoreboard bench for adder_flit_injector: default run, stall, ignored
// starts, back-to-back packets, empty run and mid-run reset.
module tb_adder_flit_injector;

  localparam int N = 30;

  localparam logic [59:0] TB_ROM [24] = '{
    60'h000000000000000, 60'hFFFFFFFFE000000, 60'h003FFFFFFFFFFFF, 60'h000000000007FFF,
    60'hFFFFF0000000000, 60'h0000000FFFFFFFF, 60'hFFFFFFFFFFFF000, 60'h00000000000000F,
    60'hFFFF00000000000, 60'h0000FFFFFFFFFFF, 60'hFFFFFFFFFFFFFF0, 60'h000000003FFFFFF,
    60'hFFFFFFFFFFFFFFF, 60'h00000FFFFFFFFFF, 60'hFFFFFFC00000000, 60'h0000000000003FF,
    60'hFFFFFFFFFF80000, 60'h001FFFFFFFFFFFF, 60'hF00000000000000, 60'h0000000001FFFFF,
    60'hFFFFFFFF0000000, 60'h00000000000FFFF, 60'hFFF800000000000, 60'h07FFFFFFFFFFFFF
  };

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         last;
    logic [7:0]   pkt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, start1, start2;
  logic [7:0] pkt0, pkt1, pkt2;
  logic       busy0, busy1, busy2;
  logic       window0, window1, window2;
  logic       done0, done1, done2;

  always #5 clk = ~clk;

  adder_flit_injector_if #(.N(N)) bus0 ();
  adder_flit_injector_if #(.N(N)) bus1 ();
  adder_flit_injector_if #(.N(N)) bus2 ();

  adder_flit_injector #(.N(N), .PAYLOAD(20), .GAP(7), .NUM_PKT(10)) u_dflt (
    .clk(clk), .rst_n(rst_n), .start(start0), .op(bus0),
    .pkt_cnt(pkt0), .busy(busy0), .window(window0), .done(done0)
  );

  adder_flit_injector #(.N(N), .PAYLOAD(24), .GAP(0), .NUM_PKT(2)) u_b2b (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(bus1),
    .pkt_cnt(pkt1), .busy(busy1), .window(window1), .done(done1)
  );

  adder_flit_injector #(.N(N), .PAYLOAD(20), .GAP(7), .NUM_PKT(0)) u_empty (
    .clk(clk), .rst_n(rst_n), .start(start2), .op(bus2),
    .pkt_cnt(pkt2), .busy(busy2), .window(window2), .done(done2)
  );

  function automatic void push_run(input int payload, input int npkt);
    exp_t        e;
    logic [59:0] w;
    for (int p = 0; p < npkt; p++) begin
      for (int j = 0; j < payload; j++) begin
        w      = TB_ROM[(j + 1) % 24];
        e.a    = w[29:0];
        e.b    = w[59:30];
        e.last = (j == payload - 1);
        e.pkt  = 8'(p);
        sb.push_back(e);
      end
    end
  endfunction

  task automatic test_reset;
    rst_n  = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    bus0.op_ready = 1'b1; bus1.op_ready = 1'b1; bus2.op_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus0.op_valid, bus0.op_a, bus0.op_b, bus0.last_flit, pkt0, busy0, window0, done0} !== '0) begin
      errors++;
      $display("FAIL reset_dflt got valid=%b a=%h b=%h last=%b pkt=%0d busy=%b win=%b done=%b, all zero required",
               bus0.op_valid, bus0.op_a, bus0.op_b, bus0.last_flit, pkt0, busy0, window0, done0);
    end
    checks++;
    if ({bus1.op_valid, bus1.op_a, pkt1, busy1, window1, done1, bus2.op_valid, busy2, done2} !== '0) begin
      errors++;
      $display("FAIL reset_others got b2b valid=%b a=%h busy=%b done=%b empty valid=%b done=%b, all zero required",
               bus1.op_valid, bus1.op_a, busy1, done1, bus2.op_valid, done2);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_default;
    exp_t        e;
    logic [59:0] w20;
    int first_valid = -1, done_cyc = -1, done_cnt = 0, gap_len = 0;
    logic in_gap = 1'b0;
    w20 = TB_ROM[20];
    sb.delete();
    push_run(20, 10);
    start0 = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      #1;
      if (bus0.op_valid) begin
        if (first_valid < 0) begin
          first_valid = c;
          checks++;
          if (bus0.op_a !== 30'h3E000000 || bus0.op_b !== 30'h3FFFFFFF) begin
            errors++;
            $display("FAIL first_flit got a=%h b=%h, required a=3e000000 b=3fffffff", bus0.op_a, bus0.op_b);
          end
        end
        if (in_gap) begin
          checks++;
          if (gap_len != 7) begin
            errors++;
            $display("FAIL gap_len c=%0d got %0d, required 7", c, gap_len);
          end
          in_gap = 1'b0; gap_len = 0;
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL extra_flit c=%0d got a=%h, required none", c, bus0.op_a);
        end else begin
          e = sb.pop_front();
          if ({bus0.op_a, bus0.op_b, bus0.last_flit, pkt0} !== {e.a, e.b, e.last, e.pkt}) begin
            errors++;
            $display("FAIL flit c=%0d got a=%h b=%h last=%b pkt=%0d, required a=%h b=%h last=%b pkt=%0d",
                     c, bus0.op_a, bus0.op_b, bus0.last_flit, pkt0, e.a, e.b, e.last, e.pkt);
          end
        end
      end else if (busy0) begin
        in_gap = 1'b1; gap_len++;
        checks++;
        if ({bus0.op_a, bus0.op_b, window0} !== {w20[29:0], w20[59:30], 1'b1}) begin
          errors++;
          $display("FAIL gap_hold c=%0d got a=%h b=%h win=%b, required a=%h b=%h win=1",
                   c, bus0.op_a, bus0.op_b, window0, w20[29:0], w20[59:30]);
        end
      end
      if (done0) begin
        done_cnt++;
        done_cyc = c;
      end
    end
    checks++;
    if (first_valid != 1) begin errors++; $display("FAIL first_latency got %0d, required 1", first_valid); end
    checks++;
    if (done_cyc != 265 || done_cnt != 1) begin
      errors++;
      $display("FAIL done_timing got cycle=%0d count=%0d, required cycle=265 count=1", done_cyc, done_cnt);
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL flits_missing got %0d left, required 0", sb.size()); end
    checks++;
    if ({pkt0, window0, busy0} !== {8'd9, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL after_done got pkt=%0d win=%b busy=%b, required pkt=9 win=0 busy=0", pkt0, window0, busy0);
    end
  endtask

  task automatic test_stall;
    exp_t        e;
    logic [59:0] w3;
    int done_cyc = -1, gap_len = 0, pkt1_cyc = -1, last0_cyc = -1;
    logic in_gap = 1'b0;
    w3 = TB_ROM[3];
    sb.delete();
    push_run(20, 10);
    start0 = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      bus0.op_ready = !(c >= 3 && c <= 7);
      #1;
      if (!bus0.op_ready) begin
        checks++;
        if ({bus0.op_valid, bus0.op_a, bus0.op_b, bus0.last_flit} !== {1'b1, w3[29:0], w3[59:30], 1'b0}) begin
          errors++;
          $display("FAIL stall_hold c=%0d got valid=%b a=%h b=%h last=%b, required valid=1 a=%h b=%h last=0",
                   c, bus0.op_valid, bus0.op_a, bus0.op_b, bus0.last_flit, w3[29:0], w3[59:30]);
        end
      end
      if (bus0.op_valid && bus0.op_ready) begin
        if (in_gap) begin
          checks++;
          if (gap_len != 7) begin errors++; $display("FAIL stall_gap c=%0d got %0d, required 7", c, gap_len); end
          in_gap = 1'b0; gap_len = 0;
        end
        if (pkt0 == 8'd1 && pkt1_cyc < 0) pkt1_cyc = c;
        if (bus0.last_flit && pkt0 == 8'd0) last0_cyc = c;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL stall_extra c=%0d got a=%h, required none", c, bus0.op_a);
        end else begin
          e = sb.pop_front();
          if ({bus0.op_a, bus0.op_b, bus0.last_flit, pkt0} !== {e.a, e.b, e.last, e.pkt}) begin
            errors++;
            $display("FAIL stall_flit c=%0d got a=%h b=%h last=%b pkt=%0d, required a=%h b=%h last=%b pkt=%0d",
                     c, bus0.op_a, bus0.op_b, bus0.last_flit, pkt0, e.a, e.b, e.last, e.pkt);
          end
        end
      end else if (!bus0.op_valid && busy0) begin
        in_gap = 1'b1; gap_len++;
      end
      if (done0) done_cyc = c;
    end
    bus0.op_ready = 1'b1;
    checks++;
    if (last0_cyc != 25 || pkt1_cyc != 33) begin
      errors++;
      $display("FAIL stall_stretch got last0=%0d pkt1=%0d, required last0=25 pkt1=33", last0_cyc, pkt1_cyc);
    end
    checks++;
    if (done_cyc != 270) begin errors++; $display("FAIL stall_done got %0d, required 270", done_cyc); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL stall_missing got %0d left, required 0", sb.size()); end
  endtask

  task automatic test_start_ignored;
    int valid_cnt = 0, done_cyc = -1, late_valid = 0;
    start0 = 1'b1;
    for (int c = 1; c <= 280; c++) begin
      @(negedge clk);
      // pulses land in SEND (5), GAP (23) and the done cycle (265)
      start0 = (c == 5 || c == 23 || c == 265);
      #1;
      if (bus0.op_valid) begin
        if (c > 265) late_valid++;
        else valid_cnt++;
      end
      if (done0) done_cyc = c;
    end
    start0 = 1'b0;
    checks++;
    if (valid_cnt != 200 || done_cyc != 265) begin
      errors++;
      $display("FAIL start_ignored got flits=%0d done=%0d, required flits=200 done=265", valid_cnt, done_cyc);
    end
    checks++;
    if (late_valid != 0 || busy0 !== 1'b0 || pkt0 !== 8'd9) begin
      errors++;
      $display("FAIL start_at_done got late=%0d busy=%b pkt=%0d, required late=0 busy=0 pkt=9",
               late_valid, busy0, pkt0);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int valid_cnt = 0, first = -1, last = -1, done_cyc = -1;
    sb.delete();
    push_run(24, 2);
    start1 = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      #1;
      if (c == 24) begin
        checks++;
        if ({bus1.op_valid, bus1.op_a, bus1.op_b, bus1.last_flit} !== {1'b1, 60'd0, 1'b1}) begin
          errors++;
          $display("FAIL wrap_flit got valid=%b a=%h b=%h last=%b, required valid=1 a=0 b=0 last=1",
                   bus1.op_valid, bus1.op_a, bus1.op_b, bus1.last_flit);
        end
      end
      if (c == 25) begin
        checks++;
        if ({bus1.op_valid, bus1.op_a, bus1.op_b, pkt1} !== {1'b1, 30'h3E000000, 30'h3FFFFFFF, 8'd1}) begin
          errors++;
          $display("FAIL no_bubble got valid=%b a=%h b=%h pkt=%0d, required valid=1 a=3e000000 b=3fffffff pkt=1",
                   bus1.op_valid, bus1.op_a, bus1.op_b, pkt1);
        end
      end
      if (bus1.op_valid) begin
        valid_cnt++;
        if (first < 0) first = c;
        last = c;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra c=%0d got a=%h, required none", c, bus1.op_a);
        end else begin
          e = sb.pop_front();
          if ({bus1.op_a, bus1.op_b, bus1.last_flit, pkt1} !== {e.a, e.b, e.last, e.pkt}) begin
            errors++;
            $display("FAIL b2b_flit c=%0d got a=%h b=%h last=%b pkt=%0d, required a=%h b=%h last=%b pkt=%0d",
                     c, bus1.op_a, bus1.op_b, bus1.last_flit, pkt1, e.a, e.b, e.last, e.pkt);
          end
        end
      end
      if (done1) done_cyc = c;
    end
    checks++;
    if (valid_cnt != 48 || first != 1 || last != 48 || done_cyc != 50) begin
      errors++;
      $display("FAIL b2b_span got flits=%0d first=%0d last=%0d done=%0d, required 48 1 48 50",
               valid_cnt, first, last, done_cyc);
    end
  endtask

  task automatic test_zero_pkt;
    int done_cyc = -1, done_cnt = 0, activity = 0;
    start2 = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      #1;
      if (bus2.op_valid || window2 || busy2) activity++;
      if (done2) begin done_cnt++; done_cyc = c; end
    end
    checks++;
    if (done_cyc != 2 || done_cnt != 1 || activity != 0) begin
      errors++;
      $display("FAIL zero_pkt got done=%0d count=%0d activity=%0d, required done=2 count=1 activity=0",
               done_cyc, done_cnt, activity);
    end
  endtask

  task automatic test_reset_midrun;
    start0 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus0.op_valid, bus0.op_a, bus0.op_b, bus0.last_flit, pkt0, busy0, window0, done0} !== '0) begin
      errors++;
      $display("FAIL async_reset got valid=%b a=%h b=%h pkt=%0d busy=%b win=%b, all zero required",
               bus0.op_valid, bus0.op_a, bus0.op_b, pkt0, busy0, window0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    #1;
    checks++;
    if ({bus0.op_valid, bus0.op_a, bus0.op_b, pkt0, window0} !== {1'b1, 30'h3E000000, 30'h3FFFFFFF, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL restart got valid=%b a=%h b=%h pkt=%0d win=%b, required valid=1 a=3e000000 b=3fffffff pkt=0 win=1",
               bus0.op_valid, bus0.op_a, bus0.op_b, pkt0, window0);
    end
    rst_n = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default();
    test_stall();
    test_start_ignored();
    test_back_to_back();
    test_zero_pkt();
    test_reset_midrun();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_flit_injector.md
Name: adder_flit_injector

Overview:
- Synthesizable operand-stream generator that sits directly upstream of the adder under energy characterization.
- Emits packets of PAYLOAD flits, each flit drawn from a fixed 24-entry, 2N-bit transition-pattern ROM.
- Each flit is split into the two adder operands, and packets are separated by GAP idle cycles.
- Provides a valid/ready handshake and a measurement window so switching-activity capture covers exactly the traffic.

Parameters:
- N, 30: operand width; each ROM word is 2N bits.
- PAYLOAD, 20: flits per packet (1..255).
- GAP, 7: idle cycles between packets (0..255); 0 means packets run back-to-back.
- NUM_PKT, 10: packets per run (0..255).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle run request.
- op_ready  input  1  downstream accepts the current flit.
- op_valid  output  1  op_a/op_b carry a flit.
- op_a  output  N  low half of the flit, ROM[idx][N-1:0].
- op_b  output  N  high half of the flit, ROM[idx][2N-1:N].
- last_flit  output  1  current flit is the final flit of its packet.
- pkt_cnt  output  8  index of the current packet.
- busy  output  1  run in progress.
- window  output  1  measurement window.
- done  output  1  one-cycle end-of-run pulse.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state IDLE; all outputs 0; internal counters 0.
- Reset asserted mid-run: all outputs go to 0 immediately and the run is abandoned; no done pulse.
- Register rule: all outputs are registered.
- Operand hold rule: op_a/op_b keep their last flit value during GAP, DONE and IDLE, so no spurious toggling reaches the adder.
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE:
  - start=1 with NUM_PKT>0 -> SEND on the next edge. In that cycle op_valid=1, op_a/op_b = ROM[1], pkt_cnt=0, busy=1, window=1. Start-to-first-flit latency is 1 cycle.
  - start=1 with NUM_PKT=0 -> DONE directly.
- Flit index: the ROM index restarts at 1 for every packet. Flit j of a packet uses ROM[(j+1) mod 24], so index 23 is followed by index 0. With the default PAYLOAD=20 each packet uses ROM[1]..ROM[20].
- SEND, handshake:
  - A flit is transferred when op_valid && op_ready.
  - While op_ready=0, op_a, op_b, last_flit and the flit counter hold. Stall length is unbounded.
  - last_flit=1 when the flit counter equals PAYLOAD-1.
- SEND, on the last flit of a packet accepted:
  - Final packet (pkt_cnt==NUM_PKT-1): -> DONE, op_valid=0.
  - Otherwise, GAP>0: -> GAP, op_valid=0, gap counter loaded with GAP.
  - Otherwise (GAP=0): stay in SEND, pkt_cnt+1, op_a/op_b = ROM[1] on the next cycle with no bubble.
- GAP:
  - Lasts exactly GAP cycles and ignores op_ready.
  - Then -> SEND with pkt_cnt+1 and flit ROM[1].
  - window stays 1 throughout.
- DONE:
  - Lasts one cycle with done=1, busy=0, window=0, op_valid=0; then -> IDLE.
  - pkt_cnt holds its final value until the next start.
- start is ignored when busy=1 or in DONE.
- Simultaneous events: a start in the same cycle as done is ignored.
- window rises with the first op_valid and falls in the DONE cycle.

Decomposition:
- Package adder_char_pkg holds:
  - ROM_DEPTH=24 and the pattern ROM constant (24 x 60-bit words, thermometer-style patterns).
  - Entries begin: 0x000000000000000, 0xFFFFFFFFE000000, 0x003FFFFFFFFFFFF, 0x000000000007FFF, 0xFFFFF0000000000. Entry 12 is all ones.
  - The state enum.
- The package ROM is sized at 60 bits; the block uses the low 2N bits.
- Sub-module pattern_rom: a combinational index-to-word lookup. The FSM/counters stay in the top module.

Test Plan:
- Reset, then start with defaults and op_ready=1 tied high:
  - First valid flit 1 cycle after start, op_a=0x3E000000, op_b=0x3FFFFFFF.
  - 20 consecutive flits, last_flit on the 20th.
  - 7 idle cycles with op_a/op_b holding the ROM[20] halves.
  - 10 packets in total, done pulses once at cycle 1+10*20+9*7+1=265 after start.
- op_ready low for 5 cycles at flit 3: op_a/op_b/last_flit frozen, ROM[3] delivered exactly once, packet stretched by 5 cycles, gap length unchanged at 7.
- GAP=0, PAYLOAD=24, NUM_PKT=2: the 24th flit is ROM[0] (zero). The next cycle carries ROM[1] with pkt_cnt=1 and no bubble; total 48 flits.
- NUM_PKT=0: done asserts 2 cycles after start, with no op_valid and no window.
- Start pulsed during SEND and during GAP: no restart, counts unaffected.
- rst_n low mid-packet: outputs are 0 before the next clock edge. A subsequent start restarts from ROM[1] with pkt_cnt=0.
